fpu_issue_arbiter: RTL

Shares the single non-pipelined floating-point execution unit between `NUM_REQ` requesters (integer pipe, vector lanes, load/convert path). Round-robin arbitration, one operation in flight, and a result held for the owning requester. Operands are rejected up front when their formats are inconsistent or invalid, and a hung unit is cut off by a watchdog. The block sits between the issue stage and the FP unit.

---
 rtl/fpu_issue_arbiter_pkg.sv | 44 ++++
 rtl/fpu_issue_arbiter_rr_picker.sv | 45 ++++
 rtl/fpu_issue_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_arbiter_pkg.sv
// ============================================================================
// Module   : fpu_issue_arbiter_pkg
// Brief    : Shared FP operand/opcode types and arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_issue_arbiter_pkg;

    typedef enum logic [1:0] {
        FT_HALF   = 2'b00,
        FT_SINGLE = 2'b01,
        FT_DOUBLE = 2'b10,
        FT_RSVD   = 2'b11
    } fType_t;

    typedef struct packed {
        logic [1:0]  ftype;
        logic [63:0] value;
    } float_t;

    localparam int FLOAT_W = $bits(float_t);

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpOp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } fpuArbState_t;

    function automatic logic is_valid_ftype(input logic [1:0] ftype);
        return ftype != FT_RSVD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_issue_arbiter_rr_picker.sv
// ============================================================================
// Module   : fpu_issue_arbiter_rr_picker
// Brief    : One-hot round-robin picker; first request at or after the pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_arbiter_rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = 0; i < N; i++) begin
            // Wrap the candidate index without a modulo so non-power-of-two N works
            w_sum = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_idx = w_sum[IW-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_issue_arbiter.sv
// ============================================================================
// Module   : fpu_issue_arbiter
// Brief    : Round-robin sharing of one non-pipelined FP unit with format
//            pre-check, held response and BUSY watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_arbiter
    import fpu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][1:0]         req_op,
    input  logic [NUM_REQ-1:0][FLOAT_W-1:0] req_a,
    input  logic [NUM_REQ-1:0][FLOAT_W-1:0] req_b,
    output logic                            fpu_start,
    output logic [1:0]                      fpu_op,
    output logic [FLOAT_W-1:0]              fpu_a,
    output logic [FLOAT_W-1:0]              fpu_b,
    input  logic                            fpu_done,
    input  logic [FLOAT_W-1:0]              fpu_result,
    output logic                            resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]      resp_id,
    output logic [FLOAT_W-1:0]              resp_result,
    output logic                            resp_error,
    input  logic                            resp_ready
);

    localparam int                c_IW        = $clog2(NUM_REQ);
    localparam int                c_WW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [c_WW-1:0]   c_WAIT_LAST = c_WW'(MAX_WAIT - 1);
    localparam logic [c_IW-1:0]   c_ID_LAST   = c_IW'(NUM_REQ - 1);

    fpuArbState_t        r_state;
    fpuArbState_t        w_next_state;
    logic [c_IW-1:0]     r_rr_ptr;
    logic [c_IW-1:0]     r_id;
    fpOp_t               r_op;
    float_t              r_a;
    float_t              r_b;
    logic [FLOAT_W-1:0]  r_result;
    logic                r_error;
    logic [c_WW-1:0]     r_wait;

    logic [NUM_REQ-1:0]  w_grant;
    logic [c_IW-1:0]     w_grant_idx;
    logic                w_any;
    float_t              w_sel_a;
    float_t              w_sel_b;
    logic                w_fmt_ok;
    logic                w_timeout;

    fpu_issue_arbiter_rr_picker #(
        .N  (NUM_REQ),
        .IW (c_IW)
    ) u_picker (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_sel_a   = float_t'(req_a[w_grant_idx]);
    assign w_sel_b   = float_t'(req_b[w_grant_idx]);
    assign w_fmt_ok  = (w_sel_a.ftype == w_sel_b.ftype) && is_valid_ftype(w_sel_a.ftype);
    assign w_timeout = (r_wait == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        fpu_start    = 1'b0;
        resp_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                req_ready = w_grant;
                if (w_any) begin
                    w_next_state = w_fmt_ok ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                fpu_start    = 1'b1;
                w_next_state = ST_BUSY;
            end
            ST_BUSY: begin
                if (fpu_done || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_wait   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id  <= w_grant_idx;
                        r_op  <= fpOp_t'(req_op[w_grant_idx]);
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_error  <= !w_fmt_ok;
                        r_result <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_wait <= '0;
                end
                ST_BUSY: begin
                    // A done on the watchdog's final cycle still counts as success
                    if (fpu_done) begin
                        r_result <= fpu_result;
                        r_error  <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + c_WW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_rr_ptr <= (r_id == c_ID_LAST) ? '0 : r_id + c_IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign fpu_op      = r_op;
    assign fpu_a       = r_a;
    assign fpu_b       = r_b;
    assign resp_id     = r_id;
    assign resp_result = r_result;
    assign resp_error  = r_error;

endmodule

`default_nettype wire
